// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Bundle of the fetch queue's memory request/response, redirect
//               and instruction-delivery signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // Fetch queue side.
    modport master (
        output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    // Memory / CPU side.
    modport slave (
        input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction prefetch queue. Issues sequential word fetches,
//               buffers in-order responses with their addresses, and flushes
//               and re-steers on a CPU redirect, discarding stale responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_b,
    fetch_queue_if.master bus
);
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_sum_w = c_cnt_w + 2;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_sum_w-1:0] c_depth_sum = c_sum_w'(FIFO_DEPTH);
    localparam logic [31:0]        c_start_pc  = {RESET_PC[31:2], 2'b00};

    logic [31:0]        r_fetch_pc;    // address of the next request
    logic [31:0]        r_rsp_pc;      // address of the next kept response
    logic [c_cnt_w-1:0] r_outstanding; // requests issued, response not yet seen
    logic [c_cnt_w-1:0] r_drop_cnt;    // outstanding responses to discard
    logic [c_cnt_w-1:0] r_count;       // FIFO occupancy
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [31:0]        r_inst_mem [FIFO_DEPTH];
    logic [31:0]        r_pc_mem   [FIFO_DEPTH];

    logic [31:0]        w_redirect_pc;
    logic [c_sum_w-1:0] w_credit_sum;
    logic               w_req_valid;
    logic               w_req_hs;
    logic               w_inst_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    // Conservative credit: dropped responses are still counted against space.
    assign w_credit_sum = {2'b00, r_outstanding} + {2'b00, r_count} + {2'b00, r_drop_cnt};
    assign w_req_valid  = reset_b && !bus.redirect_valid && (w_credit_sum < c_depth_sum);
    assign w_req_hs     = w_req_valid && bus.mem_req_ready;

    assign w_inst_valid = (r_count != '0);
    assign w_pop        = w_inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign w_push       = bus.mem_rsp_valid && !bus.redirect_valid && (r_drop_cnt == '0);
    assign w_drop       = bus.mem_rsp_valid && !bus.redirect_valid && (r_drop_cnt != '0);

    assign bus.mem_req_valid = w_req_valid;
    assign bus.mem_req_addr  = r_fetch_pc;
    assign bus.inst_valid    = w_inst_valid;
    assign bus.inst          = r_inst_mem[r_rd_ptr];
    assign bus.inst_pc       = r_pc_mem[r_rd_ptr];

    // Fetch and response address tracking; both re-steer on a redirect.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_fetch_pc <= c_start_pc;
            r_rsp_pc   <= c_start_pc;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
        end else begin
            if (w_req_hs) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push)   r_rsp_pc   <= r_rsp_pc + 32'd4;
        end
    end

    // In-flight request count and the number of those to be discarded.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            case ({w_req_hs, bus.mem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + c_cnt_w'(1);
                2'b01:   r_outstanding <= r_outstanding - c_cnt_w'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (bus.redirect_valid)
                r_drop_cnt <= bus.mem_rsp_valid ? (r_outstanding - c_cnt_w'(1)) : r_outstanding;
            else if (w_drop)
                r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while held.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_inst_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
            end
        end else if (w_push) begin
            r_inst_mem[r_wr_ptr] <= bus.mem_rsp_data;
            r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    // Protocol checks: the credit rule must keep these from ever firing.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_b)
        !(w_push && !w_pop && (r_count == c_depth_cnt)));
    a_rsp_has_req: assert property (@(posedge clk) disable iff (!reset_b)
        !(bus.mem_rsp_valid && (r_outstanding == '0)));
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!reset_b)
        (r_outstanding <= c_depth_cnt));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue with a simple
//               fixed-latency, always-ready instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic clk     = 1'b0;
    logic reset_b = 1'b0;

    fetch_queue_if bus();

    fetch_queue #(.FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    int          cycle    = 0;
    int          lat      = 1;
    int          hs_count = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] hs_addr   [$];
    logic [31:0] got_pc    [$];
    logic [31:0] got_inst  [$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Called at a falling edge (or pre ns before the next rising edge):
    // samples handshakes just before the rising edge, then plays the memory.
    task automatic tick(input int pre = 4);
        #(pre);
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            pend_addr.push_back(bus.mem_req_addr);
            pend_due.push_back(cycle + lat);
            hs_addr.push_back(bus.mem_req_addr);
            hs_count++;
        end
        if (bus.inst_valid && bus.inst_ready) begin
            got_pc.push_back(bus.inst_pc);
            got_inst.push_back(bus.inst);
        end
        @(negedge clk);
        cycle++;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        if (pend_due.size() > 0 && pend_due[0] <= cycle) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_data(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    endtask

    task automatic clear_model();
        pend_addr.delete(); pend_due.delete(); hs_addr.delete();
        got_pc.delete(); got_inst.delete();
        hs_count = 0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    task automatic start_test(input int latency);
        reset_b = 1'b0;
        clear_model();
        bus.inst_ready = 1'b0;
        lat = latency;
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.mem_req_valid); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", bus.inst_valid); end
        checks++; if (bus.mem_req_addr !== RESET_PC) begin errors++; $display("FAIL reset_req_addr: got %h expected %h", bus.mem_req_addr, RESET_PC); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus.inst); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", bus.inst_pc); end
        tick(); tick();
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_req_valid: got %b expected 0", bus.mem_req_valid); end
        reset_b = 1'b1;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid: got %b expected 1", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== RESET_PC) begin errors++; $display("FAIL release_req_addr: got %h expected %h", bus.mem_req_addr, RESET_PC); end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        start_test(1);
        bus.inst_ready = 1'b1;
        tick();
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL stream_latency_early: got %b expected 0", bus.inst_valid); end
        tick();
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stream_latency_valid: got %b expected 1", bus.inst_valid); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL stream_first_pc: got %h expected 0", bus.inst_pc); end
        repeat (10) tick();
        checks++; if (hs_count !== 12) begin errors++; $display("FAIL stream_req_count: got %0d expected 12", hs_count); end
        checks++; if (got_pc.size() !== 10) begin errors++; $display("FAIL stream_count: got %0d expected 10", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++; if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== mem_data(32'(4 * i))) begin
                errors++; $display("FAIL stream_seq[%0d]: got pc %h inst %h expected pc %h inst %h", i, got_pc[i], got_inst[i], 32'(4 * i), mem_data(32'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        start_test(1);
        repeat (10) tick();
        checks++; if (hs_count !== 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", hs_count); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", bus.mem_req_valid); end
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got valid %b pc %h expected valid 1 pc 0", bus.inst_valid, bus.inst_pc); end
        bus.inst_ready = 1'b1;
        repeat (12) tick();
        checks++; if (got_pc.size() !== 12) begin errors++; $display("FAIL bp_drain_count: got %0d expected 12", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++; if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== mem_data(32'(4 * i))) begin
                errors++; $display("FAIL bp_seq[%0d]: got pc %h inst %h expected pc %h", i, got_pc[i], got_inst[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        start_test(4);
        bus.inst_ready = 1'b1;
        repeat (3) tick();
        checks++; if (hs_count !== 3) begin errors++; $display("FAIL redir_inflight: got %0d expected 3", hs_count); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_withdraw: got %b expected 0", bus.mem_req_valid); end
        tick(3);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #1;
        checks++; if (bus.mem_req_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_addr: got %h expected 00000100", bus.mem_req_addr); end
        tick(3);
        repeat (13) tick();
        checks++; if (hs_addr.size() < 4 || hs_addr[3] !== 32'h0000_0100) begin errors++; $display("FAIL redir_next_req: got %0d reqs expected 4th at 00000100", hs_addr.size()); end
        checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL redir_count: got %0d expected at least 2", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++; if (got_pc[i] !== 32'h100 + 32'(4 * i) || got_inst[i] !== mem_data(32'h100 + 32'(4 * i))) begin
                errors++; $display("FAIL redir_seq[%0d]: got pc %h inst %h expected pc %h", i, got_pc[i], got_inst[i], 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back();
        start_test(4);
        bus.inst_ready = 1'b1;
        tick(); tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0040;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h40) begin errors++; $display("FAIL b2b_credit: got valid %b addr %h expected valid 0 addr 00000040", bus.mem_req_valid, bus.mem_req_addr); end
        tick(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0080;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h80) begin errors++; $display("FAIL b2b_req: got valid %b addr %h expected valid 1 addr 00000080", bus.mem_req_valid, bus.mem_req_addr); end
        tick(3);
        repeat (13) tick();
        checks++; if (got_pc.size() < 4) begin errors++; $display("FAIL b2b_count: got %0d expected at least 4", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++; if (got_pc[i] !== 32'h80 + 32'(4 * i) || got_inst[i] !== mem_data(32'h80 + 32'(4 * i))) begin
                errors++; $display("FAIL b2b_seq[%0d]: got pc %h inst %h expected pc %h", i, got_pc[i], got_inst[i], 32'h80 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        start_test(1);
        bus.inst_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_req: got valid %b addr %h expected valid 1 addr fffffff8", bus.mem_req_valid, bus.mem_req_addr); end
        tick(3);
        repeat (7) tick();
        checks++; if (got_pc.size() !== 6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", got_pc.size()); end
        for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
            checks++; if (got_pc[i] !== exp_pc[i] || got_inst[i] !== mem_data(exp_pc[i])) begin
                errors++; $display("FAIL wrap_seq[%0d]: got pc %h inst %h expected pc %h", i, got_pc[i], got_inst[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_test(3);
        repeat (5) tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL midrst_pre: got valid %b pc %h expected valid 1 pc 0", bus.inst_valid, bus.inst_pc); end
        reset_b = 1'b0;
        clear_model();
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_inst_valid: got %b expected 0", bus.inst_valid); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_req_valid: got %b expected 0", bus.mem_req_valid); end
        @(negedge clk);
        lat = 1;
        bus.inst_ready = 1'b1;
        reset_b = 1'b1;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RESET_PC) begin errors++; $display("FAIL midrst_release: got valid %b addr %h expected valid 1 addr %h", bus.mem_req_valid, bus.mem_req_addr, RESET_PC); end
        tick(3);
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: got %b expected 0", bus.inst_valid); end
        repeat (5) tick();
        checks++; if (got_pc.size() !== 4) begin errors++; $display("FAIL midrst_count: got %0d expected 4", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++; if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== mem_data(32'(4 * i))) begin
                errors++; $display("FAIL midrst_seq[%0d]: got pc %h inst %h expected pc %h", i, got_pc[i], got_inst[i], 32'(4 * i));
            end
        end
    endtask

    initial begin
        bus.mem_req_ready  = 1'b1;
        bus.inst_ready     = 1'b0;
        clear_model();
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
